pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard/sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Combines three stall sources into per-stage register enables and flushes: the register-scoreboard RAW stall, taken jumps resolved in EX, and data-memory handshake waits.
- Drives `stall_jmp_mem` back to the scoreboard so that it does not record the destination of an instruction blocked in ID.
- Keeps saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1: bubble cycles injected into ID/EX after a taken jump (range 1-3).
- MEM_TIMEOUT, 15: MEM_WAIT cycles without `mem_ack` before a fatal error.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- sb_stall  in  1  RAW hazard from the scoreboard
- jmp  in  1  taken jump/branch in EX, one-cycle pulse
- mem_req  in  1  load/store present in MEM stage
- mem_ack  in  1  data memory completes the request this cycle
- imem_ready  in  1  instruction fetch data valid
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
- if_id_flush, id_ex_flush  out  1 each  load NOP into that stage register
- stall_jmp_mem  out  1  ID issue blocked by jump/memory; to scoreboard
- mem_err  out  1  sticky memory timeout
- stall_cycles  out  CNT_W  cycles with pc_en=0, saturating
- flush_count  out  CNT_W  taken jumps accepted, saturating

Behaviour:
- States: RUN, MEM_WAIT, FLUSH, ERR. Control outputs are combinational from state and inputs. Counters, `mem_err`, `jmp_pending` and the flush/timeout counters are registered.
- While `rst`=1: all enables 0, both flushes 1, `stall_jmp_mem`=0. On the next edge: state RUN, `mem_err`=0, counters 0, `jmp_pending`=0. Reset mid-MEM_WAIT or mid-FLUSH aborts the operation with no residue.
- RUN priority: memory wait > jump > RAW stall > fetch stall > normal.
  - Memory wait (`mem_req`=1 & `mem_ack`=0): all enables 0, `stall_jmp_mem`=1; next state MEM_WAIT, timeout counter cleared. If `jmp`=1 in the same cycle, set `jmp_pending`.
  - Jump (`jmp`=1): all enables 1, `if_id_flush`=`id_ex_flush`=1, `stall_jmp_mem`=1, `flush_count`+1. `sb_stall` is ignored because the ID instruction is wrong-path. If FLUSH_CYCLES>1, go to FLUSH with remaining=FLUSH_CYCLES-1.
  - RAW stall (`sb_stall`=1): `pc_en`=`if_id_en`=0, `id_ex_flush`=1; EX/MEM/WB advance.
  - Fetch stall (`imem_ready`=0): `pc_en`=0, `if_id_flush`=1; the rest advance.
  - Normal: all enables 1, no flush.
- `mem_req`&`mem_ack` in the same cycle: no stall.
- MEM_WAIT:
  - Outputs as for the memory-wait case; the timeout counter increments each cycle.
  - On `mem_ack`=1: all enables 1 this cycle.
    - If `jmp_pending`: perform the jump actions, clear `jmp_pending`, go to FLUSH or RUN.
    - Otherwise go to RUN.
  - `jmp` seen while in MEM_WAIT also sets `jmp_pending` (EX is frozen, so it is the same jump). It is counted once.
  - If the counter reaches MEM_TIMEOUT with no ack: set `mem_err`, go to ERR.
- FLUSH:
  - Outputs: `pc_en`=`if_id_en`=1, `id_ex_flush`=1, `stall_jmp_mem`=1, EX/MEM/WB enabled.
  - Decrement remaining; at 0 return to RUN.
  - A new `jmp` restarts the flush and counts.
  - A memory wait preempts FLUSH; the remaining count is preserved and FLUSH is resumed after ack.
- ERR: all enables 0, flushes 0, `mem_err`=1, counters frozen, until `rst`.
- `stall_cycles` increments on every non-reset cycle with `pc_en`=0, including ERR-free states. Both counters saturate at all-ones.

Decomposition:
- Shared include `riscv_ctrl_defs.vh`: state encodings (2-bit: RUN=0, MEM_WAIT=1, FLUSH=2, ERR=3) and default FLUSH_CYCLES/MEM_TIMEOUT.
- One sub-module `sat_counter` (WIDTH param; inc/clr; saturating), instantiated for `stall_cycles`, `flush_count` and the memory timeout.

Test Plan:
1. Reset, then `imem_ready`=1, all other inputs 0 for 5 cycles -> all enables 1, no flushes, `stall_cycles`=0.
2. `sb_stall`=1 for 2 cycles -> `pc_en`=`if_id_en`=0, `id_ex_flush`=1 for both cycles, `stall_cycles`=2, `stall_jmp_mem`=0.
3. `jmp`=1 together with `sb_stall`=1 -> both flushes 1, all enables 1, `stall_jmp_mem`=1, `flush_count`=1. With FLUSH_CYCLES=3 -> 2 further cycles with `id_ex_flush`=1.
4. `mem_req`=1 with `mem_ack` low for 4 cycles, `jmp` pulsed on cycle 2, then ack -> 4 cycles of all enables 0 and `stall_jmp_mem`=1; on the ack cycle both flushes 1 and `flush_count`=1.
5. `mem_req`=1 with no ack for 15 cycles -> `mem_err`=1, state ERR, enables 0. Then `rst` -> `mem_err`=0, counters 0.
6. Assert `rst` during FLUSH (remaining=2) -> next cycle RUN, no flush asserted after reset release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and default timing parameters.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam int DEF_FLUSH_CYCLES = 1;
  localparam int DEF_MEM_TIMEOUT  = 15;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: merges RAW, jump and
// data-memory stalls into stage enables/flushes and keeps perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_stall,
  input  logic             jmp,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall_jmp_mem,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int         TMR_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] FLUSH_REM = 2'(FLUSH_CYCLES - 1);

  state_t     state_reg, state_next;
  logic       jmp_pending_reg, jmp_pending_next;
  logic [1:0] remaining_reg, remaining_next;
  logic       mem_err_reg, mem_err_next;

  logic       mem_wait;
  logic [4:0] en;
  logic       stall_inc, flush_inc, tmr_inc, tmr_clr;
  logic [TMR_W-1:0] tmr_count;

  assign mem_wait = mem_req & ~mem_ack;
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;

  always_comb begin
    state_next       = state_reg;
    jmp_pending_next = jmp_pending_reg;
    remaining_next   = remaining_reg;
    mem_err_next     = mem_err_reg;
    en               = '0;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    stall_jmp_mem    = 1'b0;
    flush_inc        = 1'b0;
    tmr_inc          = 1'b0;
    tmr_clr          = 1'b0;

    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (mem_wait) begin
            stall_jmp_mem = 1'b1;
            state_next    = MEM_WAIT;
            tmr_clr       = 1'b1;
            if (jmp) jmp_pending_next = 1'b1;
          end else if (jmp) begin
            // ID holds a wrong-path instruction, so sb_stall is irrelevant here
            en            = '1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            stall_jmp_mem = 1'b1;
            flush_inc     = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next     = FLUSH;
              remaining_next = FLUSH_REM;
            end
          end else if (sb_stall) begin
            en          = 5'b00111;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            en          = 5'b01111;
            if_id_flush = 1'b1;
          end else begin
            en = '1;
          end
        end

        MEM_WAIT: begin
          if (mem_ack) begin
            en = '1;
            if (jmp_pending_reg || jmp) begin
              if_id_flush      = 1'b1;
              id_ex_flush      = 1'b1;
              stall_jmp_mem    = 1'b1;
              flush_inc        = 1'b1;
              jmp_pending_next = 1'b0;
              if (FLUSH_CYCLES > 1) begin
                state_next     = FLUSH;
                remaining_next = FLUSH_REM;
              end else begin
                state_next     = RUN;
                remaining_next = '0;
              end
            end else if (remaining_reg != 2'd0) begin
              // resume a flush that this memory wait preempted
              state_next = FLUSH;
            end else begin
              state_next = RUN;
            end
          end else begin
            stall_jmp_mem = 1'b1;
            tmr_inc       = 1'b1;
            if (jmp) jmp_pending_next = 1'b1;
            if (tmr_count == TMR_W'(MEM_TIMEOUT - 1)) begin
              mem_err_next = 1'b1;
              state_next   = ERR;
            end
          end
        end

        FLUSH: begin
          if (mem_wait) begin
            stall_jmp_mem = 1'b1;
            state_next    = MEM_WAIT;
            tmr_clr       = 1'b1;
            if (jmp) jmp_pending_next = 1'b1;
          end else if (jmp) begin
            en             = '1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            stall_jmp_mem  = 1'b1;
            flush_inc      = 1'b1;
            remaining_next = FLUSH_REM;
          end else begin
            en             = '1;
            id_ex_flush    = 1'b1;
            stall_jmp_mem  = 1'b1;
            remaining_next = remaining_reg - 2'd1;
            if (remaining_reg == 2'd1) state_next = RUN;
          end
        end

        ERR: begin
          mem_err_next = 1'b1;
        end
      endcase
    end
  end

  assign stall_inc = ~rst & ~en[4] & (state_reg != ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      jmp_pending_reg <= 1'b0;
      remaining_reg   <= 2'd0;
      mem_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      jmp_pending_reg <= jmp_pending_next;
      remaining_reg   <= remaining_next;
      mem_err_reg     <= mem_err_next;
    end
  end

  assign mem_err = mem_err_reg;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_inc),
    .count (flush_count)
  );

  sat_counter #(.WIDTH(TMR_W)) u_mem_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .count (tmr_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table plus hand sequences for timeout,
// error recovery and counter saturation, checked through an expectation queue.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst, sb_stall, jmp, mem_req, mem_ack, imem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, stall_jmp_mem, mem_err;
  logic [3:0] stall_cycles, flush_count;

  typedef struct packed {
    logic rst, sb, jmp, req, ack, imem;
  } in_t;

  typedef struct packed {
    logic [4:0] en;
    logic [1:0] fl;
    logic       sjm;
    logic       err;
    logic [3:0] sc;
    logic [3:0] fc;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .sb_stall      (sb_stall),
    .jmp           (jmp),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .imem_ready    (imem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .stall_jmp_mem (stall_jmp_mem),
    .mem_err       (mem_err),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  function automatic out_t mko(logic [4:0] en, logic [1:0] fl, logic sjm,
                               logic err, logic [3:0] sc, logic [3:0] fc);
    out_t o;
    o.en = en; o.fl = fl; o.sjm = sjm; o.err = err; o.sc = sc; o.fc = fc;
    return o;
  endfunction

  // input bits ordered {rst, sb_stall, jmp, mem_req, mem_ack, imem_ready}
  function automatic vec_t mk(logic [5:0] i, logic [4:0] en, logic [1:0] fl,
                              logic sjm, logic [3:0] sc, logic [3:0] fc);
    vec_t v;
    v.i = in_t'(i);
    v.o = mko(en, fl, sjm, 1'b0, sc, fc);
    return v;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("en=%b fl=%b sjm=%b err=%b sc=%0d fc=%0d",
                     o.en, o.fl, o.sjm, o.err, o.sc, o.fc);
  endfunction

  task automatic step(input in_t i, input out_t e, input string name);
    out_t got, want;
    @(posedge clk);
    #1;
    {rst, sb_stall, jmp, mem_req, mem_ack, imem_ready} = i;
    exp_q.push_back(e);
    @(negedge clk);
    got = mko({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
              {if_id_flush, id_ex_flush}, stall_jmp_mem, mem_err,
              stall_cycles, flush_count);
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %s required %s", name, fmt(got), fmt(want));
    end else begin
      $display("ok   %s: %s", name, fmt(got));
    end
  endtask

  initial begin
    {rst, sb_stall, jmp, mem_req, mem_ack} = 5'b10000;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset, idle, RAW stall, jump + RAW, fetch stall
    tbl.push_back(mk(6'b100001, 5'b00000, 2'b11, 1'b0, 4'd0, 4'd0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd0, 4'd0));
    tbl.push_back(mk(6'b010001, 5'b00111, 2'b01, 1'b0, 4'd0, 4'd0));
    tbl.push_back(mk(6'b010001, 5'b00111, 2'b01, 1'b0, 4'd1, 4'd0));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd2, 4'd0));
    tbl.push_back(mk(6'b011001, 5'b11111, 2'b11, 1'b1, 4'd2, 4'd0));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd2, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd2, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd2, 4'd1));
    tbl.push_back(mk(6'b000000, 5'b01111, 2'b10, 1'b0, 4'd2, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd3, 4'd1));
    // memory wait with jump pulsed on its second cycle, then ack
    tbl.push_back(mk(6'b000101, 5'b00000, 2'b00, 1'b1, 4'd3, 4'd1));
    tbl.push_back(mk(6'b001101, 5'b00000, 2'b00, 1'b1, 4'd4, 4'd1));
    tbl.push_back(mk(6'b000101, 5'b00000, 2'b00, 1'b1, 4'd5, 4'd1));
    tbl.push_back(mk(6'b000101, 5'b00000, 2'b00, 1'b1, 4'd6, 4'd1));
    tbl.push_back(mk(6'b000111, 5'b11111, 2'b11, 1'b1, 4'd7, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd7, 4'd2));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd7, 4'd2));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd7, 4'd2));
    tbl.push_back(mk(6'b000111, 5'b11111, 2'b00, 1'b0, 4'd7, 4'd2));
    // memory wait preempting a flush, flush resumed after ack
    tbl.push_back(mk(6'b001001, 5'b11111, 2'b11, 1'b1, 4'd7, 4'd2));
    tbl.push_back(mk(6'b000101, 5'b00000, 2'b00, 1'b1, 4'd7, 4'd3));
    tbl.push_back(mk(6'b000111, 5'b11111, 2'b00, 1'b0, 4'd8, 4'd3));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd8, 4'd3));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd8, 4'd3));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd8, 4'd3));
    // jump during flush restarts it
    tbl.push_back(mk(6'b001001, 5'b11111, 2'b11, 1'b1, 4'd8, 4'd3));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd8, 4'd4));
    tbl.push_back(mk(6'b001001, 5'b11111, 2'b11, 1'b1, 4'd8, 4'd4));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd8, 4'd5));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd8, 4'd5));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd8, 4'd5));
    // reset during flush, then reset during memory wait
    tbl.push_back(mk(6'b001001, 5'b11111, 2'b11, 1'b1, 4'd8, 4'd5));
    tbl.push_back(mk(6'b100001, 5'b00000, 2'b11, 1'b0, 4'd8, 4'd6));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd0, 4'd0));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd0, 4'd0));
    tbl.push_back(mk(6'b000101, 5'b00000, 2'b00, 1'b1, 4'd0, 4'd0));
    tbl.push_back(mk(6'b100101, 5'b00000, 2'b11, 1'b0, 4'd1, 4'd0));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd0, 4'd0));
    // jump in the same cycle as a memory wait
    tbl.push_back(mk(6'b001101, 5'b00000, 2'b00, 1'b1, 4'd0, 4'd0));
    tbl.push_back(mk(6'b000111, 5'b11111, 2'b11, 1'b1, 4'd1, 4'd0));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd1, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b01, 1'b1, 4'd1, 4'd1));
    tbl.push_back(mk(6'b000001, 5'b11111, 2'b00, 1'b0, 4'd1, 4'd1));

    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].i, tbl[k].o, $sformatf("tbl[%0d]", k));

    // timeout: 1 RUN cycle + 15 MEM_WAIT cycles without ack, then ERR
    step(in_t'(6'b100001), mko(5'b00000, 2'b11, 1'b0, 1'b0, 4'd1, 4'd1), "to_rst");
    for (int k = 1; k <= 16; k++)
      step(in_t'(6'b000101),
           mko(5'b00000, 2'b00, 1'b1, 1'b0, 4'((k - 1 > 15) ? 15 : k - 1), 4'd0),
           $sformatf("to_wait%0d", k));
    for (int k = 17; k <= 19; k++)
      step(in_t'(6'b000101), mko(5'b00000, 2'b00, 1'b0, 1'b1, 4'd15, 4'd0),
           $sformatf("to_err%0d", k));
    step(in_t'(6'b000001), mko(5'b00000, 2'b00, 1'b0, 1'b1, 4'd15, 4'd0), "err_hold");
    step(in_t'(6'b100001), mko(5'b00000, 2'b11, 1'b0, 1'b1, 4'd15, 4'd0), "err_rst");
    step(in_t'(6'b000001), mko(5'b11111, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0), "err_clr");

    // flush_count saturation over 17 jumps
    for (int k = 0; k < 17; k++) begin
      step(in_t'(6'b001001),
           mko(5'b11111, 2'b11, 1'b1, 1'b0, 4'd0, 4'((k > 15) ? 15 : k)),
           $sformatf("sat_jmp%0d", k));
      for (int f = 0; f < 2; f++)
        step(in_t'(6'b000001),
             mko(5'b11111, 2'b01, 1'b1, 1'b0, 4'd0, 4'((k + 1 > 15) ? 15 : k + 1)),
             $sformatf("sat_fl%0d_%0d", k, f));
    end
    step(in_t'(6'b000001), mko(5'b11111, 2'b00, 1'b0, 1'b0, 4'd0, 4'd15), "sat_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
